// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with false-start and framing-error rejection, feeding a
// small byte FIFO popped with a valid/ready handshake.
module uart_rx_fifo #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       SerialIn,
   output logic [7:0] DataOut,
   output logic       DataOutValid,
   input  logic       DataOutReady,
   output logic       FramingError,
   output logic       Overflow,
   input  logic       ErrClear
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;
   localparam int AW               = $clog2(FIFO_DEPTH);
   localparam int NW               = AW + 1;

   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
   localparam logic [CW-1:0] EDGE_LAST   = CW'(SYMBOL_EDGE_TIME - 1);
   localparam logic [AW-1:0] PTR_ONE     = AW'(1);
   localparam logic [NW-1:0] NUM_ONE     = NW'(1);
   localparam logic [NW-1:0] NUM_FULL    = NW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic          sync1_r;
   logic          rx_r;
   state_t        state_r,   state_s;
   logic [CW-1:0] cnt_r,     cnt_s;
   logic [2:0]    bit_idx_r, bit_idx_s;
   logic [7:0]    shift_r,   shift_s;
   logic          push_s;
   logic          ferr_s;
   logic          ferr_r;

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [NW-1:0] count_r;
   logic          ovf_r;
   logic          full_s;
   logic          pop_s;
   logic          push_ok_s;
   logic          ovf_set_s;

   // Receiver next-state: mid-bit sampling driven by the cycle counter.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r + CNT_ONE;
      bit_idx_s = bit_idx_r;
      shift_s   = shift_r;
      push_s    = 1'b0;
      ferr_s    = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_s = '0;
            if (!rx_r) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (cnt_r == SAMPLE_LAST) begin
               cnt_s     = '0;
               bit_idx_s = 3'd0;
               if (rx_r) begin
                  state_s = IDLE;
               end else begin
                  state_s = DATA;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_r == EDGE_LAST) begin
               shift_s   = {rx_r, shift_r[7:1]};
               cnt_s     = '0;
               bit_idx_s = bit_idx_r + 3'd1;
               if (bit_idx_r == 3'd7) begin
                  state_s = STOP;
               end else begin
                  state_s = DATA;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit lets a following start bit be caught with no idle gap.
            if (cnt_r == EDGE_LAST) begin
               cnt_s   = '0;
               state_s = IDLE;
               if (rx_r) begin
                  push_s = 1'b1;
               end else begin
                  ferr_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // Synchronizer and receiver state registers.
   always_ff @(posedge CLK) begin
      if (reset) begin
         sync1_r   <= 1'b1;
         rx_r      <= 1'b1;
         state_r   <= IDLE;
         cnt_r     <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         ferr_r    <= 1'b0;
      end else begin
         sync1_r   <= SerialIn;
         rx_r      <= sync1_r;
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_idx_r <= bit_idx_s;
         shift_r   <= shift_s;
         ferr_r    <= ferr_s;
      end
   end

   // FIFO handshake decode; a pop when empty never frees a slot.
   always_comb begin
      full_s    = (count_r == NUM_FULL);
      pop_s     = DataOutReady && (count_r != '0);
      push_ok_s = push_s && (!full_s || pop_s);
      ovf_set_s = push_s && full_s && !pop_s;
   end

   // FIFO storage is deliberately left unreset.
   always_ff @(posedge CLK) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= shift_r;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge CLK) begin
      if (reset) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
         ovf_r    <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + NUM_ONE;
            2'b01:   count_r <= count_r - NUM_ONE;
            default: count_r <= count_r;
         endcase
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (ErrClear) begin
            ovf_r <= 1'b0;
         end
      end
   end

   assign DataOut      = mem_r[rd_ptr_r];
   assign DataOutValid = (count_r != '0);
   assign FramingError = ferr_r;
   assign Overflow     = ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written
// overflow, full-with-pop, glitch and mid-frame reset sequences.
module tb_uart_rx_fifo;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic       SerialIn = 1'b1;
   logic [7:0] DataOut;
   logic       DataOutValid;
   logic       DataOutReady = 1'b0;
   logic       FramingError;
   logic       Overflow;
   logic       ErrClear = 1'b0;

   int n_vec = 0;
   int n_mis = 0;
   int ferr_cnt = 0;
   logic watch_en = 1'b0;
   logic bad_seen = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs [6];

   uart_rx_fifo #(
      .CLOCK_FREQ(1000),
      .BAUD_RATE (100),
      .FIFO_DEPTH(4)
   ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .SerialIn    (SerialIn),
      .DataOut     (DataOut),
      .DataOutValid(DataOutValid),
      .DataOutReady(DataOutReady),
      .FramingError(FramingError),
      .Overflow    (Overflow),
      .ErrClear    (ErrClear)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (FramingError) ferr_cnt++;
      if (watch_en && DataOutValid && (DataOut !== 8'h7E)) bad_seen = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK);
         SerialIn = v;
      end
   endtask

   // Ten bit periods of ten cycles each; optional pop lands on the stop-bit sampling edge.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_push);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (c == 0) SerialIn = bits[b];
            if (pop_at_push) DataOutReady = (b == 9) && (c == 7);
         end
      end
   endtask

   task automatic pop_chk(input logic [7:0] exp);
      chk("pop valid", {31'd0, DataOutValid}, 32'd1);
      chk("pop data", {24'd0, DataOut}, {24'd0, exp});
      DataOutReady = 1'b1;
      @(negedge CLK);
      DataOutReady = 1'b0;
   endtask

   initial begin
      int f0;
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
      vecs[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 0};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};

      repeat (3) @(negedge CLK);
      chk("reset valid", {31'd0, DataOutValid}, 32'd0);
      chk("reset ferr", {31'd0, FramingError}, 32'd0);
      chk("reset ovf", {31'd0, Overflow}, 32'd0);
      reset = 1'b0;
      drive_bit(1'b1, 5);

      for (int i = 0; i < 6; i++) begin
         f0 = ferr_cnt;
         send_frame(vecs[i].data, vecs[i].stop, 1'b0);
         drive_bit(1'b1, 20);
         chk("vec valid", {31'd0, DataOutValid}, {31'd0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            chk("vec data", {24'd0, DataOut}, {24'd0, vecs[i].exp_data});
            drive_bit(1'b1, 5);
            chk("vec hold", {31'd0, DataOutValid}, 32'd1);
         end
         chk("vec ferr pulses", ferr_cnt - f0, vecs[i].exp_ferr);
         DataOutReady = 1'b1;
         @(negedge CLK);
         DataOutReady = 1'b0;
         chk("vec after pop", {31'd0, DataOutValid}, 32'd0);
      end
      chk("no ovf after table", {31'd0, Overflow}, 32'd0);

      // False start: three low cycles only.
      f0 = ferr_cnt;
      drive_bit(1'b0, 3);
      drive_bit(1'b1, 30);
      chk("glitch valid", {31'd0, DataOutValid}, 32'd0);
      chk("glitch ferr", ferr_cnt - f0, 32'd0);
      send_frame(8'h5A, 1'b1, 1'b0);
      drive_bit(1'b1, 5);
      pop_chk(8'h5A);

      // Five back-to-back frames into a four-entry FIFO.
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0);
      drive_bit(1'b1, 5);
      chk("ovf set", {31'd0, Overflow}, 32'd1);
      for (int k = 1; k <= 4; k++) pop_chk(8'(k));
      chk("ovf drained valid", {31'd0, DataOutValid}, 32'd0);
      chk("ovf sticky", {31'd0, Overflow}, 32'd1);
      ErrClear = 1'b1;
      @(negedge CLK);
      ErrClear = 1'b0;
      chk("ovf cleared", {31'd0, Overflow}, 32'd0);

      // Full FIFO with a pop on the same edge as the fifth push.
      for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0);
      send_frame(8'h05, 1'b1, 1'b1);
      drive_bit(1'b1, 5);
      chk("push+pop no ovf", {31'd0, Overflow}, 32'd0);
      for (int k = 2; k <= 5; k++) pop_chk(8'(k));
      chk("push+pop drained", {31'd0, DataOutValid}, 32'd0);

      // Reset during data bit 4, then a clean frame.
      f0 = ferr_cnt;
      watch_en = 1'b1;
      drive_bit(1'b0, 10);
      drive_bit(1'b1, 10);
      drive_bit(1'b0, 10);
      drive_bit(1'b1, 10);
      drive_bit(1'b1, 10);
      @(negedge CLK);
      SerialIn = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge CLK);
      reset = 1'b0;
      SerialIn = 1'b1;
      drive_bit(1'b1, 150);
      chk("rst no push", {31'd0, DataOutValid}, 32'd0);
      send_frame(8'h7E, 1'b1, 1'b0);
      drive_bit(1'b1, 5);
      chk("rst frame valid", {31'd0, DataOutValid}, 32'd1);
      chk("rst frame data", {24'd0, DataOut}, 32'h7E);
      DataOutReady = 1'b1;
      @(negedge CLK);
      DataOutReady = 1'b0;
      drive_bit(1'b1, 5);
      chk("rst frame popped", {31'd0, DataOutValid}, 32'd0);
      chk("rst ferr", ferr_cnt - f0, 32'd0);
      chk("rst only 7E", {31'd0, bad_seen}, 32'd0);
      watch_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side serial front end for the CPU's memory-mapped UART; its byte-stream outputs drive the datapath's DataOut / DataOutValid inputs.
- Deserializes 8N1 frames from the serial pin, rejects false starts and framing errors, and buffers good bytes in a small FIFO.
- The datapath pops bytes with DataOutReady (its REUART strobe).

Parameters:
- CLOCK_FREQ, 100_000_000: CLK frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- FIFO_DEPTH, 4: byte buffer entries; must be a power of 2, ≥2.
- Derived (localparam): SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer divide); SAMPLE_TIME = SYMBOL_EDGE_TIME/2.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- SerialIn  in  1  asynchronous serial line; idles high.
- DataOut  out  8  byte at FIFO head; don't-care when DataOutValid=0.
- DataOutValid  out  1  FIFO non-empty.
- DataOutReady  in  1  consumer pop request; a byte transfers on any cycle with DataOutValid && DataOutReady.
- FramingError  out  1  one-cycle pulse when a frame's stop bit samples 0.
- Overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full.
- ErrClear  in  1  clears Overflow.

Behaviour:
- Synchronizer
  - SerialIn passes through two flops; both reset to 1.
  - All receiver logic uses the second flop (rx_s). Pin-to-rx_s latency is 2 cycles.
- Receiver FSM: IDLE, START, DATA, STOP.
  - Cycle counter: clog2(SYMBOL_EDGE_TIME)+1 bits wide.
  - Bit index: 3 bits.
  - Shift register: 8 bits, LSB-first; each sampled bit enters at bit 7 and shifts right.
- IDLE: on rx_s==0, clear the counter and go to START.
- START
  - When counter reaches SAMPLE_TIME-1, sample rx_s.
  - If 1 (glitch): return to IDLE with no output.
  - If 0: clear counter and bit index, go to DATA.
- DATA
  - When counter reaches SYMBOL_EDGE_TIME-1, sample rx_s into the shift register, clear the counter, increment the bit index.
  - After the 8th sample (index wraps 7→0), go to STOP.
- STOP
  - When counter reaches SYMBOL_EDGE_TIME-1, sample rx_s, then go to IDLE.
  - Returning to IDLE at mid-stop-bit allows back-to-back frames with zero idle time.
  - Sample 1: push the shift-register byte to the FIFO (subject to the full rule below).
  - Sample 0: FramingError=1 for exactly that next cycle; byte discarded.
- FIFO
  - Storage: FIFO_DEPTH×8 registers, plus read pointer, write pointer, and count (clog2(FIFO_DEPTH)+1 bits). Pointers wrap modulo FIFO_DEPTH.
  - DataOut is driven from storage[rd_ptr]; it is not registered again.
  - Push-to-visible latency: a byte pushed at edge N is on DataOut with DataOutValid=1 after edge N.
  - Pop when empty (Ready with Valid=0): ignored; pointers unchanged.
  - Push when full, no simultaneous pop: byte dropped, Overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds when full (the pop frees the slot; no overflow). When empty, the push is accepted and the pop is ignored.
- Overflow
  - ErrClear=1 clears Overflow.
  - If ErrClear and a new overflow occur in the same cycle, set wins (Overflow=1).
- Reset values
  - FSM=IDLE; counter, bit index, pointers, count = 0.
  - DataOutValid=0, FramingError=0, Overflow=0; synchronizer flops = 1.
  - FIFO storage is not reset.
- Reset mid-frame: partial frame abandoned, no push, no error. After reset deasserts, the receiver waits for a new falling edge. If the line is low at reset release, that counts as a start bit.

Test Plan (sim params: CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10 and SAMPLE_TIME=5; FIFO_DEPTH=4):
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), DataOutReady=0 → DataOut=0xA5, DataOutValid=1, held until a pop. One pop cycle → DataOutValid=0.
- SerialIn low for 3 cycles then high → no push, FramingError stays 0, FSM back in IDLE.
- Frame 0x3C with stop bit driven 0 → FramingError high exactly 1 cycle, DataOutValid stays 0. Next good frame 0x11 → received correctly.
- Five back-to-back frames 0x01..0x05, no pops → FIFO holds 0x01..0x04, Overflow=1. Four pops return 0x01,0x02,0x03,0x04. ErrClear pulse → Overflow=0.
- FIFO full (0x01..0x04), DataOutReady held 1 in the same cycle as the 0x05 push → Overflow stays 0. Pops return 0x02..0x05.
- reset asserted at data bit 4 of a frame, released, then frame 0x7E sent → only 0x7E is ever presented, with no error pulses.
